// File: rtl/key_packer_if.sv
// rtl/key_packer_if.sv - scancode event input and FIFO write-port bundle for key_packer
interface key_packer_if;
    logic         key_valid;
    logic         key_ready;
    logic [8:0]   key_code;
    logic         key_is_mod;
    logic         frame_end;
    logic         fifo_full;
    logic         fifo_wr;
    logic [125:0] fifo_dout;
    logic         overflow;
    logic [3:0]   mod_count;
    logic [2:0]   key_count;

    modport master (
        output key_valid, key_code, key_is_mod, frame_end, fifo_full,
        input  key_ready, fifo_wr, fifo_dout, overflow, mod_count, key_count
    );

    modport slave (
        input  key_valid, key_code, key_is_mod, frame_end, fifo_full,
        output key_ready, fifo_wr, fifo_dout, overflow, mod_count, key_count
    );
endinterface

// File: rtl/key_packer.sv
// rtl/key_packer.sv - packs 9-bit scancode events into 14-slot 126-bit keyboard FIFO words
module key_packer #(
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    key_packer_if.slave bus
);
    localparam int              CW       = $clog2(IDLE_TIMEOUT);
    localparam logic [CW-1:0]   TMO_LAST = CW'(IDLE_TIMEOUT - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        PUSH    = 1'b1
    } state_t;

    state_t        state_q;
    logic [8:0]    mod_q [8];
    logic [8:0]    mod_d [8];
    logic [8:0]    key_q [6];
    logic [8:0]    key_d [6];
    logic [3:0]    mod_cnt_q, mod_cnt_d;
    logic [2:0]    key_cnt_q, key_cnt_d;
    logic [CW-1:0] tmo_q;
    logic [125:0]  dout_q;
    logic [125:0]  word_d;
    logic          ovf_q;

    logic mod_dup, key_dup, live, hit, full, accept, drop, non_empty_d, flush;

    // Duplicates only count against slots already in use; stale slots are always zero anyway.
    always_comb begin
        mod_dup = 1'b0;
        key_dup = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((4'(i) < mod_cnt_q) && (mod_q[i] == bus.key_code)) mod_dup = 1'b1;
        end
        for (int j = 0; j < 6; j++) begin
            if ((3'(j) < key_cnt_q) && (key_q[j] == bus.key_code)) key_dup = 1'b1;
        end
    end

    always_comb begin
        live   = (state_q == COLLECT) && bus.key_valid && (bus.key_code != 9'h0);
        hit    = bus.key_is_mod ? mod_dup : key_dup;
        full   = bus.key_is_mod ? (mod_cnt_q == 4'd8) : (key_cnt_q == 3'd6);
        accept = live && !hit && !full;
        drop   = live && !hit && full;

        mod_d     = mod_q;
        key_d     = key_q;
        mod_cnt_d = mod_cnt_q;
        key_cnt_d = key_cnt_q;
        if (accept && bus.key_is_mod) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) == mod_cnt_q) mod_d[i] = bus.key_code;
            end
            mod_cnt_d = mod_cnt_q + 4'd1;
        end
        if (accept && !bus.key_is_mod) begin
            for (int j = 0; j < 6; j++) begin
                if (3'(j) == key_cnt_q) key_d[j] = bus.key_code;
            end
            key_cnt_d = key_cnt_q + 3'd1;
        end

        non_empty_d = (mod_cnt_d != 4'd0) || (key_cnt_d != 3'd0);
        flush       = (state_q == COLLECT) && (bus.frame_end || (tmo_q == TMO_LAST)) && non_empty_d;

        // Modifier slots fill from the MSB end, key slots follow at slot 9.
        word_d = '0;
        for (int i = 0; i < 8; i++) word_d[125 - 9*i -: 9] = mod_d[i];
        for (int j = 0; j < 6; j++) word_d[53 - 9*j -: 9]  = key_d[j];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= COLLECT;
            for (int i = 0; i < 8; i++) mod_q[i] <= '0;
            for (int j = 0; j < 6; j++) key_q[j] <= '0;
            mod_cnt_q <= '0;
            key_cnt_q <= '0;
            tmo_q     <= '0;
            dout_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            ovf_q <= drop;
            case (state_q)
                COLLECT: begin
                    if (flush) begin
                        dout_q    <= word_d;
                        for (int i = 0; i < 8; i++) mod_q[i] <= '0;
                        for (int j = 0; j < 6; j++) key_q[j] <= '0;
                        mod_cnt_q <= '0;
                        key_cnt_q <= '0;
                        tmo_q     <= '0;
                        state_q   <= PUSH;
                    end else begin
                        mod_q     <= mod_d;
                        key_q     <= key_d;
                        mod_cnt_q <= mod_cnt_d;
                        key_cnt_q <= key_cnt_d;
                        if (accept || !non_empty_d) tmo_q <= '0;
                        else                        tmo_q <= tmo_q + CW'(1);
                    end
                end
                PUSH: begin
                    tmo_q <= '0;
                    if (!bus.fifo_full) state_q <= COLLECT;
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    // The write strobe follows fifo_full combinationally so a stalled FIFO never sees a write.
    assign bus.key_ready = (state_q == COLLECT);
    assign bus.fifo_wr   = (state_q == PUSH) && !bus.fifo_full;
    assign bus.fifo_dout = dout_q;
    assign bus.overflow  = ovf_q;
    assign bus.mod_count = mod_cnt_q;
    assign bus.key_count = key_cnt_q;
endmodule

// File: tb/tb_key_packer.sv
// tb/tb_key_packer.sv - randomized and directed scoreboard bench for key_packer
module tb_key_packer;
    localparam int IDLE = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    key_packer_if bus ();

    key_packer #(.IDLE_TIMEOUT(IDLE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int ovf_seen = 0;
    int wr_seen = 0;

    // Reference model: modifier and key sets as ordered queues, plus an idle-cycle tally.
    logic [8:0]   m_mods[$];
    logic [8:0]   m_keys[$];
    logic [125:0] exp_q[$];
    logic [125:0] m_word = '0;
    bit           m_push = 0;
    bit           m_ovf = 0;
    bit           m_acc = 0;
    int           m_idle = 0;

    task automatic chk(input string nm, input logic [125:0] act, input logic [125:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit has(input logic [8:0] q[$], input logic [8:0] c);
        foreach (q[i]) if (q[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [125:0] pack_word(input logic [8:0] mods[$], input logic [8:0] keys[$]);
        logic [125:0] w = '0;
        foreach (mods[i]) w[125 - 9*i -: 9] = mods[i];
        foreach (keys[j]) w[125 - 9*(8 + j) -: 9] = keys[j];
        return w;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mods.delete();
            m_keys.delete();
            exp_q.delete();
            m_push = 0;
            m_ovf  = 0;
            m_idle = 0;
        end else if (m_push) begin
            m_ovf = 0;
            if (!bus.fifo_full) m_push = 0;
        end else begin
            m_acc = 0;
            m_ovf = 0;
            if (bus.key_valid && bus.key_code != 9'h0) begin
                if (bus.key_is_mod) begin
                    if (!has(m_mods, bus.key_code)) begin
                        if (m_mods.size() == 8) m_ovf = 1;
                        else begin m_mods.push_back(bus.key_code); m_acc = 1; end
                    end
                end else begin
                    if (!has(m_keys, bus.key_code)) begin
                        if (m_keys.size() == 6) m_ovf = 1;
                        else begin m_keys.push_back(bus.key_code); m_acc = 1; end
                    end
                end
            end
            if ((bus.frame_end || m_idle == IDLE - 1) && (m_mods.size() + m_keys.size() > 0)) begin
                m_word = pack_word(m_mods, m_keys);
                exp_q.push_back(m_word);
                m_mods.delete();
                m_keys.delete();
                m_idle = 0;
                m_push = 1;
            end else if (m_acc || (m_mods.size() + m_keys.size() == 0)) begin
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("key_ready", 126'(bus.key_ready), 126'(!m_push));
            chk("fifo_wr", 126'(bus.fifo_wr), 126'(m_push && !bus.fifo_full));
            chk("overflow", 126'(bus.overflow), 126'(m_ovf));
            chk("mod_count", 126'(bus.mod_count), 126'(m_mods.size()));
            chk("key_count", 126'(bus.key_count), 126'(m_keys.size()));
            if (bus.overflow) ovf_seen++;
            if (m_push) chk("dout_hold", bus.fifo_dout, m_word);
            if (bus.fifo_wr) begin
                wr_seen++;
                if (exp_q.size() == 0) chk("unexpected_write", 126'(1), 126'(0));
                else chk("word", bus.fifo_dout, exp_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic m, input logic [8:0] c, input logic fe);
        int guard = 0;
        bus.key_valid = 1'b1; bus.key_code = c; bus.key_is_mod = m; bus.frame_end = fe;
        while (!bus.key_ready && guard < 50) begin
            if (guard >= 3) bus.fifo_full = 1'b0;
            step(1);
            guard++;
        end
        if (guard >= 50) chk("ready_timeout", 126'(0), 126'(1));
        step(1);
        bus.key_valid = 1'b0; bus.key_code = 9'h0; bus.frame_end = 1'b0;
    endtask

    task automatic pulse_frame_end();
        bus.frame_end = 1'b1;
        step(1);
        bus.frame_end = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w0;
        int o0;
        bus.key_valid = 0; bus.key_code = 0; bus.key_is_mod = 0;
        bus.frame_end = 0; bus.fifo_full = 0;
        step(3);
        reset = 1'b0;
        step(1);

        chk("rst_key_ready", 126'(bus.key_ready), 126'(1));
        chk("rst_fifo_wr", 126'(bus.fifo_wr), 126'(0));
        chk("rst_dout", bus.fifo_dout, 126'(0));
        chk("rst_counts", 126'({bus.mod_count, bus.key_count}), 126'(0));
        chk("rst_overflow", 126'(bus.overflow), 126'(0));

        // Basic pack
        send(1, 9'h012, 0);
        send(0, 9'h01C, 0);
        send(0, 9'h032, 0);
        pulse_frame_end();
        chk("basic_wr", 126'(bus.fifo_wr), 126'(1));
        chk("basic_word", bus.fifo_dout, {9'h012, 63'h0, 9'h01C, 9'h032, 36'h0});
        step(1);
        chk("basic_wr_once", 126'(bus.fifo_wr), 126'(0));
        chk("basic_counts", 126'({bus.mod_count, bus.key_count}), 126'(0));

        // Filtering and overflow
        o0 = ovf_seen;
        send(0, 9'h000, 0);
        send(0, 9'h01C, 0);
        send(0, 9'h01C, 0);
        for (int i = 0; i < 7; i++) send(0, 9'h020 + 9'(i), 0);
        step(1);
        chk("filt_key_count", 126'(bus.key_count), 126'(6));
        chk("filt_ovf_pulses", 126'(ovf_seen - o0), 126'(2));
        pulse_frame_end();
        chk("filt_wr", 126'(bus.fifo_wr), 126'(1));
        chk("filt_slot9", 126'(bus.fifo_dout[53:45]), 126'(9'h01C));
        chk("filt_slot10", 126'(bus.fifo_dout[44:36]), 126'(9'h020));
        chk("filt_slot14", 126'(bus.fifo_dout[8:0]), 126'(9'h024));
        step(1);

        // Back-pressure
        send(0, 9'h031, 0);
        bus.fifo_full = 1'b1;
        pulse_frame_end();
        bus.key_valid = 1'b1; bus.key_code = 9'h023; bus.key_is_mod = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_wr", 126'(bus.fifo_wr), 126'(0));
            chk("bp_ready", 126'(bus.key_ready), 126'(0));
            chk("bp_dout", bus.fifo_dout, {72'h0, 9'h031, 45'h0});
            step(1);
        end
        bus.fifo_full = 1'b0;
        #1;
        chk("bp_wr_release", 126'(bus.fifo_wr), 126'(1));
        @(posedge clk); #1;
        chk("bp_ready_back", 126'(bus.key_ready), 126'(1));
        chk("bp_count_before", 126'(bus.key_count), 126'(0));
        step(1);
        bus.key_valid = 1'b0; bus.key_code = 9'h0;
        chk("bp_023_accepted", 126'(bus.key_count), 126'(1));
        pulse_frame_end();
        step(2);

        // Idle timeout
        send(0, 9'h01C, 0);
        n = 0;
        while (!bus.fifo_wr && n < 20) begin step(1); n++; end
        chk("tmo_latency", 126'(n), 126'(IDLE));
        step(2);
        w0 = wr_seen;
        step(100);
        chk("tmo_empty_no_write", 126'(wr_seen - w0), 126'(0));

        // Event and frame_end together on an empty word
        send(0, 9'h029, 1);
        chk("simul_wr", 126'(bus.fifo_wr), 126'(1));
        chk("simul_slot9", 126'(bus.fifo_dout[53:45]), 126'(9'h029));
        step(2);

        // Reset in the middle of PUSH
        send(1, 9'h011, 0);
        bus.fifo_full = 1'b1;
        pulse_frame_end();
        #2 reset = 1'b1;
        #1;
        chk("rstpush_wr", 126'(bus.fifo_wr), 126'(0));
        chk("rstpush_counts", 126'({bus.mod_count, bus.key_count}), 126'(0));
        @(posedge clk); #3;
        reset = 1'b0;
        bus.fifo_full = 1'b0;
        step(1);
        w0 = wr_seen;
        pulse_frame_end();
        step(5);
        chk("rstpush_no_write", 126'(wr_seen - w0), 126'(0));

        // Randomized traffic
        for (int it = 0; it < 600; it++) begin
            bus.fifo_full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) != 0) begin
                send(1'($urandom_range(0, 1)), 9'($urandom_range(0, 20)), ($urandom_range(0, 7) == 0));
            end else begin
                bus.frame_end = ($urandom_range(0, 5) == 0);
                step(1);
                bus.frame_end = 1'b0;
            end
        end
        bus.fifo_full = 1'b0;
        step(30);
        chk("drain_exp_empty", 126'(exp_q.size()), 126'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/key_packer.md
Name: key_packer

Overview:
- Write-side counterpart of the keyboard scancode FIFO path.
- Collects individual 9-bit PS/2 scancode events from the HID translator into one 126-bit snapshot word of 14 slots: 8 modifier slots and 6 key slots.
- Writes each word into the keyboard FIFO, whose reader serializes the non-zero slots back out in order.
- Sits between the USB HID decode logic and the FIFO write port.

Parameters:
IDLE_TIMEOUT, 1024, cycles with no accepted event, while the word is non-empty, before an automatic flush (min 2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
key_valid  in  1  scancode event present
key_ready  out  1  event accepted this cycle when key_valid && key_ready
key_code  in  9  scancode; 9'h0 is ignored
key_is_mod  in  1  1 = modifier class (slots 1-8), 0 = key class (slots 9-14)
frame_end  in  1  end-of-report strobe; flush request
fifo_full  in  1  FIFO cannot accept a write
fifo_wr  out  1  FIFO write enable
fifo_dout  out  126  packed word
overflow  out  1  one-cycle pulse, event dropped because its class is full
mod_count  out  4  modifier slots in use (0-8)
key_count  out  3  key slots in use (0-6)

Behaviour:
- Slot layout: slot k (1..14) occupies fifo_dout[125-9*(k-1) -: 9]. Slot 1 = [125:117], slot 14 = [8:0]. Unused slots are 9'h0.
- Reset values:
  - state = COLLECT; all slots, fifo_dout, mod_count, key_count and the timeout counter = 0.
  - fifo_wr = 0, overflow = 0, key_ready = 1 after reset deasserts.
- States:
  - COLLECT: key_ready = 1. Accepted events are stored in the working slots.
  - PUSH: key_ready = 0. fifo_dout holds the latched word. fifo_wr = !fifo_full (combinational). When fifo_wr = 1 at a clock edge, return to COLLECT.
- Accepting an event in COLLECT (key_valid = 1):
  - key_code == 0: ignored, no count change.
  - Code already present in its class's slots: ignored. Duplicate check covers only the slots in use.
  - Otherwise the code goes to the next free slot of its class (mod: slot 1+mod_count; key: slot 9+key_count) and that count increments.
  - Class full (mod_count == 8 or key_count == 6): event dropped, overflow pulses high for exactly the next cycle.
- Flush trigger, evaluated in COLLECT only:
  - Fires when (frame_end || timeout) && (word non-empty after this cycle's event).
  - On the trigger edge: the working word including this cycle's event goes to fifo_dout, all slots and counts clear, the timeout counter clears, and state goes to PUSH.
  - frame_end with an empty word: no write.
  - frame_end in PUSH: ignored.
- Latency: frame_end sampled at edge N gives fifo_wr = 1 during cycle N→N+1 if !fifo_full, and the word is written at edge N+1. A full FIFO stretches PUSH indefinitely while fifo_dout stays stable.
- Timeout:
  - The counter increments each COLLECT cycle with count > 0 and no accepted non-zero, non-duplicate event.
  - It resets to 0 on any accepted event.
  - It fires when the counter reaches IDLE_TIMEOUT-1, i.e. the IDLE_TIMEOUT-th idle cycle. It is held at 0 in PUSH and while the word is empty.
- Simultaneous events:
  - key_valid + frame_end in one cycle: the event is included in the flushed word.
  - An overflowing event in the flush cycle still pulses overflow, and the word is flushed without it.
- Back-pressure: the producer must hold key_valid/key_code while key_ready = 0. No event is lost during PUSH.
- Reset mid-PUSH: the latched word is abandoned, fifo_wr drops to 0 asynchronously, and the FIFO sees no partial write.

Test Plan:
- Basic pack:
  - Stimulus: events mod 9'h012, key 9'h01C, key 9'h032, then frame_end; fifo_full = 0.
  - Required: one fifo_wr pulse one cycle after frame_end. fifo_dout[125:117] = 9'h012, [53:45] = 9'h01C, [44:36] = 9'h032, all other bits 0. Counts return to 0.
- Filtering and overflow:
  - Stimulus: key code 9'h000, then 9'h01C twice, then 7 distinct key codes.
  - Required: key_count = 6; overflow pulses once per dropped key (2 pulses); slot 9 = 9'h01C appears only once.
- Back-pressure:
  - Stimulus: fifo_full = 1 at flush for 5 cycles, with key_valid held high with 9'h023.
  - Required: fifo_wr = 0 and key_ready = 0 for those 5 cycles, fifo_dout stable; exactly one write once fifo_full falls. 9'h023 is accepted in the first COLLECT cycle after PUSH.
- Timeout (IDLE_TIMEOUT = 8):
  - Stimulus: single key 9'h01C and no frame_end.
  - Required: flush on the 8th idle cycle and fifo_wr the cycle after.
  - Stimulus: empty word held idle for 100 cycles. Required: no write.
- Simultaneous event:
  - Stimulus: key_valid with 9'h029 and frame_end in the same cycle, on an empty word.
  - Required: the written word has slot 9 = 9'h029.
- Reset mid-PUSH:
  - Stimulus: assert reset during PUSH with fifo_full = 1.
  - Required: fifo_wr = 0 immediately, counts = 0, and a subsequent frame_end on an empty word produces no write.
